ntp_time_snapshot: RTL and testbench
====================================

# ntp_time_snapshot

Downstream consumer of one NTP clock's `NTP_TIME` / `NTP_TIME_UPD` outputs that exposes the time to the host as an AXI4-Lite slave on a free PCIe-AXI bridge slot.
- Provides a tear-free (atomic) read of the live 64-bit time.
- Provides an armed snapshot captured on an update strobe.
- Counts update strobes and flags a stale clock when no update arrives within a programmable window.

## Interface
Parameters:
- STALE_LIMIT_RESET, 32'd125_000_000, reset value of the STALE_LIMIT register, in clock cycles.

Ports:
- axi_aclk  in  1  single clock. `ntp_time` and `ntp_time_upd` are synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- ntp_time  in  64  NTP time: seconds in [63:32], fraction in [31:0].
- ntp_time_upd  in  1  one-cycle strobe marking a new `ntp_time` value.
- axi_awaddr  in  5  write address; byte address, word-aligned.
- axi_awvalid / axi_awready  in / out  1  write-address handshake.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  write byte strobes.
- axi_wvalid / axi_wready  in / out  1  write-data handshake.
- axi_bresp  out  2  write response.
- axi_bvalid / axi_bready  out / in  1  write-response handshake.
- axi_araddr  in  5  read address.
- axi_arvalid / axi_arready  in / out  1  read-address handshake.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  read response.
- axi_rvalid / axi_rready  out / in  1  read-data handshake.
- stale  out  1  stale-clock flag, also visible in CTRL.

## Operation
Register map, decoded on addr[4:2]:
- 0x00 CTRL.
  - Write: bit0=ARM, bit1=CLR_CNT. Both act only if wstrb[0]=1.
  - Read: bit0=SNAP_VALID, bit1=ARMED, bit2=stale. Other bits read 0.
- 0x04 UPD_CNT (RO): 32-bit count of `ntp_time_upd` pulses. Wraps 0xFFFF_FFFF→0.
- 0x08 SNAP_HI / 0x0C SNAP_LO (RO): the captured snapshot.
- 0x10 LIVE_HI (RO): returns `ntp_time[63:32]`. In the same cycle it latches `ntp_time[31:0]` into LIVE_SHADOW.
- 0x14 LIVE_LO (RO): returns LIVE_SHADOW.
- 0x18 STALE_LIMIT (RW): per-byte writes honour wstrb.
- 0x1C: unmapped. Reads and writes return SLVERR (2'b10) with no side effect. Reads of unmapped space return rdata=0.
- All mapped accesses return OKAY (2'b00). Writes to RO registers are ignored and return OKAY.

Snapshot:
- ARM sets ARMED and clears SNAP_VALID.
- While ARMED, the first `ntp_time_upd` strictly after the write-accept cycle captures `ntp_time` into SNAP_HI/SNAP_LO, sets SNAP_VALID, and clears ARMED.
- An ARM while already ARMED restarts the arm and keeps SNAP_VALID=0.

Age and stale detection:
- AGE (internal, 32-bit) is cleared to 0 on a cycle with `ntp_time_upd`=1; otherwise it increments, saturating at 0xFFFF_FFFF.
- stale = (AGE >= STALE_LIMIT), registered. STALE_LIMIT=0 gives stale=1 permanently.

Write channel:
- AW and W are accepted together, when awvalid & wvalid & !bvalid.
- awready and wready pulse high for exactly that one cycle.
- bvalid rises the next cycle and holds until bready.

Read channel:
- arready pulses for one cycle when arvalid & !rvalid.
- rdata, rresp and rvalid are registered the next cycle.
- rvalid and rdata hold stable until rready.

## Timing
- Reset values:
  - All ready and valid outputs 0; bresp=rresp=0; rdata=0.
  - SNAP_*, LIVE_SHADOW, UPD_CNT and AGE = 0; ARMED=SNAP_VALID=0.
  - STALE_LIMIT = STALE_LIMIT_RESET; stale=0.
- Latency:
  - Write: accept at cycle N, register updated at N+1, bvalid at N+1.
  - Read: accept at N, rvalid at N+1. rdata reflects register state at cycle N; LIVE_HI samples `ntp_time` at N.
- Simultaneous events:
  - CLR_CNT write and `ntp_time_upd` in the same cycle: UPD_CNT=0.
  - ARM accept and `ntp_time_upd` in the same cycle: no capture; capture waits for the next strobe.
  - Capture and a read of SNAP_* in the same cycle: the read returns the old value.
  - AGE is not affected by CLR_CNT.
- A new STALE_LIMIT takes effect for the stale compare one cycle after the write.
- Reset asserted mid-transaction drops any pending bvalid/rvalid immediately. There is no response after reset release.

## Test plan
- Reset, then read all registers. Expected: CTRL=0, UPD_CNT=0, STALE_LIMIT=STALE_LIMIT_RESET, 0x1C → rresp=2'b10 with rdata=0.
- Atomic read: time=0x0000_0001_FFFF_FFFF, read LIVE_HI, then change time to 0x0000_0002_0000_0000 and read LIVE_LO. Expected: 0x1 then 0xFFFF_FFFF.
- Write CTRL=1; pulse upd with time=0xDEAD_BEEF_1234_5678 in the write-accept cycle, then again with 0xAAAA_BBBB_CCCC_DDDD. Expected: SNAP_HI=0xAAAA_BBBB, SNAP_LO=0xCCCC_DDDD, CTRL=0x1.
- UPD_CNT forced near wrap: 0xFFFF_FFFF plus 1 pulse → 0. Then CLR_CNT written in the same cycle as a pulse → 0.
- STALE_LIMIT=10 with no updates. Expected: stale=1 exactly 10 cycles after the last update is visible at the compare; a pulse clears stale the following cycle.
- Backpressure: hold bready and rready low for 5 cycles. Expected: bvalid, rvalid and rdata stable throughout; no second arready or awready asserted.

Source files
------------

// File: rtl/ntp_time_snapshot.sv
// AXI4-Lite view of a live NTP clock: atomic live read, armed snapshot, update count, stale flag.
// Accept at N -> register/bvalid/rvalid at N+1; responses hold until bready/rready, no new accept meanwhile.
module ntp_time_snapshot #(
    parameter logic [31:0] STALE_LIMIT_RESET = 32'd125_000_000
) (
    input  logic        axi_aclk,
    input  logic        reset,
    input  logic [63:0] ntp_time,
    input  logic        ntp_time_upd,
    input  logic [4:0]  axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [4:0]  axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic        stale
);

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_UPD_CNT = 3'd1;
    localparam logic [2:0] A_SNAP_HI = 3'd2;
    localparam logic [2:0] A_SNAP_LO = 3'd3;
    localparam logic [2:0] A_LIVE_HI = 3'd4;
    localparam logic [2:0] A_LIVE_LO = 3'd5;
    localparam logic [2:0] A_LIMIT   = 3'd6;
    localparam logic [2:0] A_UNMAP   = 3'd7;

    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;
    logic [31:0] r_upd_cnt;
    logic [31:0] r_snap_hi;
    logic [31:0] r_snap_lo;
    logic [31:0] r_live_shadow;
    logic [31:0] r_stale_limit;
    logic [31:0] r_age;
    logic        r_armed;
    logic        r_snap_valid;
    logic        r_stale;

    logic        w_wr_acc;
    logic        w_rd_acc;
    logic [2:0]  w_widx;
    logic [2:0]  w_ridx;
    logic        w_arm;
    logic        w_clr;
    logic [31:0] w_rd_dat;
    logic        w_unused;

    assign w_unused = &{1'b0, axi_awaddr[1:0], axi_araddr[1:0]};

    assign w_widx   = axi_awaddr[4:2];
    assign w_ridx   = axi_araddr[4:2];
    assign w_wr_acc = axi_awvalid & axi_wvalid & ~r_bvalid;
    assign w_rd_acc = axi_arvalid & ~r_rvalid;
    assign w_arm    = w_wr_acc & (w_widx == A_CTRL) & axi_wstrb[0] & axi_wdata[0];
    assign w_clr    = w_wr_acc & (w_widx == A_CTRL) & axi_wstrb[0] & axi_wdata[1];

    assign axi_awready = w_wr_acc;
    assign axi_wready  = w_wr_acc;
    assign axi_arready = w_rd_acc;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = r_bresp;
    assign axi_rvalid  = r_rvalid;
    assign axi_rresp   = r_rresp;
    assign axi_rdata   = r_rdata;
    assign stale       = r_stale;

    // LIVE_HI comes straight from the input so the HI/shadow pair is sampled in one cycle.
    always_comb begin
        w_rd_dat = 32'd0;
        case (w_ridx)
            A_CTRL:    w_rd_dat = {29'd0, r_stale, r_armed, r_snap_valid};
            A_UPD_CNT: w_rd_dat = r_upd_cnt;
            A_SNAP_HI: w_rd_dat = r_snap_hi;
            A_SNAP_LO: w_rd_dat = r_snap_lo;
            A_LIVE_HI: w_rd_dat = ntp_time[63:32];
            A_LIVE_LO: w_rd_dat = r_live_shadow;
            A_LIMIT:   w_rd_dat = r_stale_limit;
            default:   w_rd_dat = 32'd0;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
        end else if (w_wr_acc) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (w_widx == A_UNMAP) ? 2'b10 : 2'b00;
        end else if (axi_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= 32'd0;
        end else if (w_rd_acc) begin
            r_rvalid <= 1'b1;
            r_rresp  <= (w_ridx == A_UNMAP) ? 2'b10 : 2'b00;
            r_rdata  <= w_rd_dat;
        end else if (axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_live_shadow <= 32'd0;
        end else if (w_rd_acc && (w_ridx == A_LIVE_HI)) begin
            r_live_shadow <= ntp_time[31:0];
        end
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_upd_cnt <= 32'd0;
        end else if (w_clr) begin
            r_upd_cnt <= 32'd0;
        end else if (ntp_time_upd) begin
            r_upd_cnt <= r_upd_cnt + 32'd1;
        end
    end

    // A fresh ARM wins over a same-cycle strobe, so capture always needs a later strobe.
    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_armed      <= 1'b0;
            r_snap_valid <= 1'b0;
            r_snap_hi    <= 32'd0;
            r_snap_lo    <= 32'd0;
        end else if (w_arm) begin
            r_armed      <= 1'b1;
            r_snap_valid <= 1'b0;
        end else if (r_armed && ntp_time_upd) begin
            r_armed      <= 1'b0;
            r_snap_valid <= 1'b1;
            r_snap_hi    <= ntp_time[63:32];
            r_snap_lo    <= ntp_time[31:0];
        end
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_stale_limit <= STALE_LIMIT_RESET;
        end else if (w_wr_acc && (w_widx == A_LIMIT)) begin
            for (int b = 0; b < 4; b++) begin
                if (axi_wstrb[b]) begin
                    r_stale_limit[8*b +: 8] <= axi_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_age   <= 32'd0;
            r_stale <= 1'b0;
        end else begin
            r_stale <= (r_age >= r_stale_limit);
            if (ntp_time_upd) begin
                r_age <= 32'd0;
            end else if (r_age != 32'hFFFF_FFFF) begin
                r_age <= r_age + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ntp_time_snapshot.sv
// Randomised and directed bench for ntp_time_snapshot against a cycle-level behavioural model.
module tb_ntp_time_snapshot;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ntp_time;
    logic        ntp_time_upd;
    logic [4:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        stale;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ntp_time_snapshot dut (
        .axi_aclk(clk), .reset(reset), .ntp_time(ntp_time), .ntp_time_upd(ntp_time_upd),
        .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
        .stale(stale)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: register file and response channels, advanced once per clock.
    logic [31:0] m_cnt, m_age, m_limit, m_snap_hi, m_snap_lo, m_shadow, m_rdata;
    logic        m_armed, m_sv, m_stale, m_bvalid, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic        t_wr, t_rd, t_arm, t_clr, t_stale;
    logic [2:0]  t_wi, t_ri;

    function automatic logic [31:0] m_reg(input logic [2:0] idx, input logic [63:0] t);
        case (idx)
            3'd0: return {29'd0, m_stale, m_armed, m_sv};
            3'd1: return m_cnt;
            3'd2: return m_snap_hi;
            3'd3: return m_snap_lo;
            3'd4: return t[63:32];
            3'd5: return m_shadow;
            3'd6: return m_limit;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_age = 0; m_limit = 32'd125_000_000; m_snap_hi = 0; m_snap_lo = 0;
            m_shadow = 0; m_rdata = 0; m_armed = 0; m_sv = 0; m_stale = 0;
            m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0;
        end else begin
            t_wr    = awvalid && wvalid && !m_bvalid;
            t_rd    = arvalid && !m_rvalid;
            t_wi    = awaddr[4:2];
            t_ri    = araddr[4:2];
            t_arm   = t_wr && t_wi == 3'd0 && wstrb[0] && wdata[0];
            t_clr   = t_wr && t_wi == 3'd0 && wstrb[0] && wdata[1];
            t_stale = (m_age >= m_limit);
            if (m_bvalid && bready) m_bvalid = 0;
            if (m_rvalid && rready) m_rvalid = 0;
            if (t_rd) begin
                m_rvalid = 1;
                m_rdata  = m_reg(t_ri, ntp_time);
                m_rresp  = (t_ri == 3'd7) ? 2'b10 : 2'b00;
                if (t_ri == 3'd4) m_shadow = ntp_time[31:0];
            end
            if (t_wr) begin
                m_bvalid = 1;
                m_bresp  = (t_wi == 3'd7) ? 2'b10 : 2'b00;
            end
            if (t_clr) m_cnt = 0;
            else if (ntp_time_upd) m_cnt = m_cnt + 1;
            if (t_arm) begin
                m_armed = 1; m_sv = 0;
            end else if (m_armed && ntp_time_upd) begin
                m_armed = 0; m_sv = 1;
                m_snap_hi = ntp_time[63:32]; m_snap_lo = ntp_time[31:0];
            end
            if (t_wr && t_wi == 3'd6)
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) m_limit[8*b +: 8] = wdata[8*b +: 8];
            if (ntp_time_upd) m_age = 0;
            else if (m_age != 32'hFFFF_FFFF) m_age = m_age + 1;
            m_stale = t_stale;
        end
    end

    always @(negedge clk) begin
        chk("awready", awready, awvalid && wvalid && !m_bvalid);
        chk("wready", wready, awvalid && wvalid && !m_bvalid);
        chk("arready", arready, arvalid && !m_rvalid);
        chk("bvalid", bvalid, m_bvalid);
        chk("rvalid", rvalid, m_rvalid);
        chk("stale", stale, m_stale);
        if (m_bvalid) chk("bresp", bresp, m_bresp);
        if (m_rvalid) begin
            chk("rdata", rdata, m_rdata);
            chk("rresp", rresp, m_rresp);
        end
    end

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected handshake", nm);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input logic u);
        bit got = 0;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1; ntp_time_upd = u;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); got = awready;
            @(posedge clk); #1;
            ntp_time_upd = 0;
        end
        awvalid = 0; wvalid = 0;
        if (!got) fail("wr_accept");
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); got = bvalid;
            @(posedge clk); #1;
        end
        if (!got) fail("wr_resp");
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        bit got = 0;
        d = 32'hxxxx_xxxx; r = 2'bxx;
        @(posedge clk); #1;
        araddr = a; arvalid = 1; rready = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); got = arready;
            @(posedge clk); #1;
        end
        arvalid = 0;
        if (!got) fail("rd_accept");
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rvalid) begin got = 1; d = rdata; r = rresp; end
            @(posedge clk); #1;
        end
        rready = 0;
        if (!got) fail("rd_resp");
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        chk(nm, d, exp_d);
        chk({nm, "_resp"}, r, exp_r);
    endtask

    task automatic pulse();
        @(posedge clk); #1; ntp_time_upd = 1;
        @(posedge clk); #1; ntp_time_upd = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1; ntp_time = 0; ntp_time_upd = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0;
        wvalid = 0; bready = 0; araddr = 0; arvalid = 0; rready = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        rd_chk("rst_ctrl", 5'h00, 32'd0, 2'b00);
        rd_chk("rst_cnt", 5'h04, 32'd0, 2'b00);
        rd_chk("rst_limit", 5'h18, 32'd125_000_000, 2'b00);
        rd_chk("rst_unmapped", 5'h1C, 32'd0, 2'b10);

        ntp_time = 64'h0000_0001_FFFF_FFFF;
        rd_chk("live_hi", 5'h10, 32'h0000_0001, 2'b00);
        ntp_time = 64'h0000_0002_0000_0000;
        rd_chk("live_lo", 5'h14, 32'hFFFF_FFFF, 2'b00);

        repeat (3) pulse();
        rd_chk("cnt3", 5'h04, 32'd3, 2'b00);

        ntp_time = 64'hDEAD_BEEF_1234_5678;
        axi_write(5'h00, 32'h1, 4'hF, 1'b1);
        ntp_time = 64'hAAAA_BBBB_CCCC_DDDD;
        pulse();
        rd_chk("snap_hi", 5'h08, 32'hAAAA_BBBB, 2'b00);
        rd_chk("snap_lo", 5'h0C, 32'hCCCC_DDDD, 2'b00);
        rd_chk("ctrl_snap", 5'h00, 32'h1, 2'b00);
        rd_chk("cnt5", 5'h04, 32'd5, 2'b00);

        axi_write(5'h00, 32'h2, 4'h1, 1'b1);
        rd_chk("cnt_clr_upd", 5'h04, 32'd0, 2'b00);
        pulse();
        axi_write(5'h00, 32'h2, 4'hE, 1'b0);
        rd_chk("cnt_clr_nostrb", 5'h04, 32'd1, 2'b00);

        axi_write(5'h18, 32'd10, 4'hF, 1'b0);
        pulse();
        repeat (3) @(posedge clk);
        pulse();
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (stale) break;
        end
        chk("stale_delay", k, 12);
        pulse();
        @(negedge clk); chk("stale_hold", stale, 1'b1);
        @(negedge clk); chk("stale_clear", stale, 1'b0);

        axi_write(5'h18, 32'd0, 4'hF, 1'b0);
        pulse();
        @(negedge clk); chk("stale_lim0_a", stale, 1'b1);
        @(negedge clk); chk("stale_lim0_b", stale, 1'b1);
        axi_write(5'h18, 32'hFFFF_FFFF, 4'b0010, 1'b0);
        rd_chk("limit_bytestrb", 5'h18, 32'h0000_FF00, 2'b00);

        @(posedge clk); #1;
        awaddr = 5'h1C; wdata = 32'h3; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        k = 0;
        repeat (6) begin
            @(negedge clk); if (awready) k++;
            @(posedge clk); #1;
        end
        chk("bp_awready_cnt", k, 1);
        chk("bp_bresp", bresp, 2'b10);
        awvalid = 0; wvalid = 0; bready = 1;
        @(posedge clk); #1; bready = 0;
        araddr = 5'h1C; arvalid = 1; rready = 0;
        k = 0;
        repeat (6) begin
            @(negedge clk); if (arready) k++;
            @(posedge clk); #1;
        end
        chk("bp_arready_cnt", k, 1);
        chk("bp_rresp", rresp, 2'b10);
        chk("bp_rdata", rdata, 32'd0);
        arvalid = 0; rready = 1;
        @(posedge clk); #1; rready = 0;
        rd_chk("ctrl_after_unmapped", 5'h00, {29'd0, stale, 2'b01}, 2'b00);

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            awvalid = 1'($urandom_range(0, 1));
            wvalid  = 1'($urandom_range(0, 1));
            awaddr  = {3'($urandom_range(0, 7)), 2'b00};
            wdata   = $urandom;
            wstrb   = 4'($urandom_range(0, 15));
            if (awaddr == 5'h18 && $urandom_range(0, 1) == 0) begin
                wdata = 32'($urandom_range(0, 40));
                wstrb = 4'hF;
            end
            arvalid = 1'($urandom_range(0, 1));
            araddr  = {3'($urandom_range(0, 7)), 2'b00};
            bready  = ($urandom_range(0, 3) != 0);
            rready  = ($urandom_range(0, 3) != 0);
            ntp_time_upd = ($urandom_range(0, 7) == 0);
            ntp_time = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0; ntp_time_upd = 0; bready = 1; rready = 1;
        repeat (3) @(posedge clk);
        #1 bready = 0; rready = 0;

        awaddr = 5'h18; wdata = 32'd5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        #2 reset = 1;
        #1 chk("rst_drops_bvalid", bvalid, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        repeat (5) @(negedge clk);
        chk("no_resp_after_rst", bvalid, 1'b0);
        rd_chk("limit_after_rst", 5'h18, 32'd125_000_000, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
